// File: rtl/efm_pkg.sv
// efm_pkg: shared types and helpers for the error-feedback modulator.
// Modulus function, input clamp and word typedef; EFM_HK_MODULUS_EN selects HK modulus.
package efm_pkg;

  localparam int unsigned EFM_WIDTH = 9;

  typedef logic [EFM_WIDTH-1:0] efm_word_t;

`ifdef EFM_HK_MODULUS_EN
  localparam bit EFM_HK = 1'b1;
`else
  localparam bit EFM_HK = 1'b0;
`endif

  function automatic int unsigned efm_modulus(
    input int unsigned width,
    input int unsigned a,
    input bit          hk
  );
    int unsigned m;
    m = 32'd1 << width;
    if (hk) m = m - a;
    return m;
  endfunction

  // Inputs at or above the modulus would break e < M, so pin them to M-1.
  function automatic logic [31:0] efm_clamp(
    input logic [31:0] x,
    input logic [31:0] m
  );
    return (x >= m) ? (m - 32'd1) : x;
  endfunction

endpackage

// File: rtl/efm_mod_add.sv
// efm_mod_add: combinational modulo-M accumulate step.
// x, e in; y_next (carry) and e_next (residue) out. EFM_HK_MODULUS_EN: M = 2^WIDTH - A.
module efm_mod_add
  import efm_pkg::*;
#(
  parameter int unsigned WIDTH = EFM_WIDTH,
  parameter int unsigned A     = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] e,
  output logic             y_next,
  output logic [WIDTH-1:0] e_next
);

  localparam int unsigned M = efm_modulus(WIDTH, A, EFM_HK);

  logic [WIDTH:0] s;

`ifdef EFM_HK_MODULUS_EN
  localparam logic [WIDTH:0] M_W = (WIDTH+1)'(M);

  logic [WIDTH-1:0] xc;
  logic [WIDTH:0]   d;

  assign xc     = WIDTH'(efm_clamp(32'(x), 32'(M)));
  assign s      = {1'b0, xc} + {1'b0, e};
  assign d      = s - M_W;
  assign y_next = (s >= M_W);
  assign e_next = y_next ? d[WIDTH-1:0] : s[WIDTH-1:0];
`else
  // Power-of-two modulus: the carry bit is the output, the rest wraps.
  assign s      = {1'b0, x} + {1'b0, e};
  assign y_next = s[WIDTH];
  assign e_next = s[WIDTH-1:0];
`endif

endmodule

// File: rtl/efm.sv
// efm: first-order error-feedback modulator (delta-sigma accumulator).
// clk, rst (sync, active-high), x_i word in; y_o carry, e_o error out. Macro EFM_HK_MODULUS_EN.
module efm
  import efm_pkg::*;
#(
  parameter int unsigned WIDTH = EFM_WIDTH,
  parameter int unsigned A     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_i,
  output logic             y_o,
  output logic [WIDTH-1:0] e_o
);

  logic             y_q;
  logic [WIDTH-1:0] e_q;
  logic             y_next;
  logic [WIDTH-1:0] e_next;

  efm_mod_add #(
    .WIDTH (WIDTH),
    .A     (A)
  ) u_add (
    .x      (x_i),
    .e      (e_q),
    .y_next (y_next),
    .e_next (e_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 1'b0;
      e_q <= '0;
    end else begin
      y_q <= y_next;
      e_q <= e_next;
    end
  end

  assign y_o = y_q;
  assign e_o = e_q;

endmodule

// File: tb/tb_efm.sv
// tb_efm: directed self-checking bench for efm (WIDTH=9, A=1).
// Expectations follow EFM_HK_MODULUS_EN (M=511) or plain mode (M=512).
module tb_efm;

`ifdef EFM_HK_MODULUS_EN
  localparam int M = 511;
`else
  localparam int M = 512;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] x_i = '0;
  logic       y_o;
  logic [8:0] e_o;

  int checks = 0;
  int errors = 0;

  efm #(.WIDTH(9), .A(1)) dut (
    .clk (clk),
    .rst (rst),
    .x_i (x_i),
    .y_o (y_o),
    .e_o (e_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x_i = 9'd254;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (y_o !== 1'b0 || e_o !== 9'd0) begin
        errors++;
        $display("FAIL reset[%0d]: y=%0d e=%0d, expected y=0 e=0", i, y_o, e_o);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_seq_254();
`ifdef EFM_HK_MODULUS_EN
    int exp_e[5] = '{254, 508, 251, 505, 248};
`else
    int exp_e[5] = '{254, 508, 250, 504, 246};
`endif
    int exp_y[5] = '{0, 0, 1, 0, 1};
    int ones = 0;
    do_reset();
    x_i = 9'd254;
    for (int i = 0; i < M; i++) begin
      step();
      if (y_o === 1'b1) ones++;
      if (i < 5) begin
        checks++;
        if (e_o !== 9'(exp_e[i]) || y_o !== 1'(exp_y[i])) begin
          errors++;
          $display("FAIL seq254[%0d]: y=%0d e=%0d, expected y=%0d e=%0d",
                   i, y_o, e_o, exp_y[i], exp_e[i]);
        end
      end
    end
    checks++;
    if (ones !== 254) begin
      errors++;
      $display("FAIL ones254: got %0d, expected 254", ones);
    end
    checks++;
    if (e_o !== 9'd0) begin
      errors++;
      $display("FAIL period254: e=%0d, expected 0", e_o);
    end
  endtask

  task automatic test_clamp();
`ifdef EFM_HK_MODULUS_EN
    int exp_e[2] = '{510, 509};
`else
    int exp_e[2] = '{511, 510};
`endif
    int exp_y[2] = '{0, 1};
    int bad = 0;
    do_reset();
    x_i = 9'd511;
    for (int i = 0; i < 600; i++) begin
      step();
      if (i < 2) begin
        checks++;
        if (e_o !== 9'(exp_e[i]) || y_o !== 1'(exp_y[i])) begin
          errors++;
          $display("FAIL clamp[%0d]: y=%0d e=%0d, expected y=%0d e=%0d",
                   i, y_o, e_o, exp_y[i], exp_e[i]);
        end
      end
      if (int'(e_o) >= M) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clamp_bound: %0d cycles with e>=%0d, expected 0", bad, M);
    end
  endtask

  task automatic test_half_and_zero();
`ifdef EFM_HK_MODULUS_EN
    int exp_e[4] = '{256, 1, 257, 2};
    int hold_e = 257;
`else
    int exp_e[4] = '{256, 0, 256, 0};
    int hold_e = 256;
`endif
    int exp_y[4] = '{0, 1, 0, 1};
    do_reset();
    x_i = 9'd256;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (e_o !== 9'(exp_e[i]) || y_o !== 1'(exp_y[i])) begin
        errors++;
        $display("FAIL half[%0d]: y=%0d e=%0d, expected y=%0d e=%0d",
                 i, y_o, e_o, exp_y[i], exp_e[i]);
      end
    end
    do_reset();
    x_i = 9'd256;
    for (int i = 0; i < 3; i++) step();
    x_i = 9'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (e_o !== 9'(hold_e) || y_o !== 1'b0) begin
        errors++;
        $display("FAIL zero_hold[%0d]: y=%0d e=%0d, expected y=0 e=%0d",
                 i, y_o, e_o, hold_e);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    x_i = 9'd254;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if (e_o !== 9'd0 || y_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: y=%0d e=%0d, expected y=0 e=0", y_o, e_o);
    end
    rst = 1'b0;
    step();
    checks++;
    if (e_o !== 9'd254 || y_o !== 1'b0) begin
      errors++;
      $display("FAIL restart: y=%0d e=%0d, expected y=0 e=254", y_o, e_o);
    end
    step();
    checks++;
    if (e_o !== 9'd508 || y_o !== 1'b0) begin
      errors++;
      $display("FAIL restart2: y=%0d e=%0d, expected y=0 e=508", y_o, e_o);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_seq_254();
    test_clamp();
    test_half_and_zero();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
